// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch front end with an in-order response queue and redirect flush.
// Optional misaligned-redirect halt is enabled by defining IFQ_ALIGN_CHECK_EN.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk2,
  input  logic        reset2_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_misaligned
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

`ifdef IFQ_ALIGN_CHECK_EN
  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;
`else
  typedef enum logic [1:0] {StRun, StDrain} state_e;
`endif

  state_e        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_q_data [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_credit;
  logic [CW:0]   w_credit_sum;
  logic          w_req_valid;
  logic          w_req_hs;
  logic          w_enq;
  logic          w_deq;
  logic [31:0]   w_redir_pc;
  logic [CW-1:0] w_out_next;

`ifdef IFQ_ALIGN_CHECK_EN
  logic r_misaligned;
  logic w_redir_misaligned;

  assign w_redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc         = redirect_pc;
  assign fetch_misaligned   = r_misaligned;
`else
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb  = ^redirect_pc[1:0];
  assign w_redir_pc       = {redirect_pc[31:2], 2'b00};
  assign fetch_misaligned = 1'b0;
`endif

  // Credit covers both queued entries and requests whose responses have not returned yet.
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit     = w_credit_sum < (CW + 1)'(DEPTH);

  // Gated by reset so nothing is requested while reset is held.
  assign w_req_valid = reset2_n && (r_state == StRun) && !redirect_valid && w_credit;
  assign w_req_hs    = w_req_valid && mem_req_ready;
  assign w_enq       = mem_rsp_valid && (r_state == StRun) && !redirect_valid;
  assign w_deq       = inst_valid && inst_ready;
  assign w_out_next  = r_outstanding + CW'(w_req_hs) - CW'(mem_rsp_valid);

  assign mem_req_valid = w_req_valid;
  assign mem_req_addr  = r_fetch_pc;
  assign inst_valid    = (r_count != '0);
  assign inst_data     = r_q_data[r_rd_ptr];
  assign inst_pc       = r_q_pc[r_rd_ptr];

  always_ff @(posedge clk2 or negedge reset2_n) begin
    if (!reset2_n) begin
      r_state       <= StRun;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
`ifdef IFQ_ALIGN_CHECK_EN
      r_misaligned  <= 1'b0;
`endif
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        // Everything still in flight after this edge belongs to the old stream.
        r_discard  <= w_out_next;
        if (w_out_next != '0) begin
          r_state <= StDrain;
        end else begin
          r_state <= StRun;
        end
`ifdef IFQ_ALIGN_CHECK_EN
        r_misaligned <= w_redir_misaligned;
        if (w_redir_misaligned) begin
          r_state <= StHalt;
        end
`endif
      end else begin
        if (w_req_hs) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_enq) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        unique case (r_state)
          StRun: begin
          end
          StDrain: begin
            if (mem_rsp_valid) begin
              r_discard <= r_discard - CW'(1);
              if (r_discard == CW'(1)) begin
                r_state <= StRun;
              end
            end
          end
`ifdef IFQ_ALIGN_CHECK_EN
          StHalt: begin
            if (mem_rsp_valid && (r_discard != '0)) begin
              r_discard <= r_discard - CW'(1);
            end
          end
`endif
          default: r_state <= StRun;
        endcase
      end
    end
  end

  always_ff @(posedge clk2 or negedge reset2_n) begin
    if (!reset2_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (w_enq) begin
      r_q_data[r_wr_ptr] <= mem_rsp_data;
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue against a stream-level reference model.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk2 = 1'b0;
  logic        reset2_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fetch_misaligned;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk2             (clk2),
    .reset2_n         (reset2_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .inst_valid       (inst_valid),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .inst_ready       (inst_ready),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  // Memory model: accepted requests waiting to be answered, tagged with the stream epoch.
  mreq_t       mem_q[$];
  // Reference: PCs of instructions expected in the decode queue, oldest first.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_rsp;
  int          m_ep;
  bit          m_halt;
  bit          m_mis;
  int          cyc;
  int          lat;
  int          n_checks;
  int          n_fail;
  int          n_hs_obs;
  int          n_deq_obs;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].ep != m_ep) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    mem_q.delete();
    m_fetch = RESET_PC;
    m_rsp   = RESET_PC;
    m_halt  = 1'b0;
    m_mis   = 1'b0;
    m_ep++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, RESET_PC);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);
  endtask

  // Called at a falling edge; returns at the next falling edge with reset released.
  task automatic do_reset(input int cycles);
    reset2_n       = 1'b0;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_req_ready  = 1'b0;
    inst_ready     = 1'b0;
    #1;
    check_reset_outputs();
    repeat (cycles) @(posedge clk2);
    @(negedge clk2);
    check_reset_outputs();
    reset2_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request, advance model.
  task automatic step(input bit rv, input logic [31:0] rpc, input bit mrdy, input bit irdy);
    bit          rsp;
    bit          exp_rv;
    bit          req_hs;
    bit          deq;
    mreq_t       e;
    logic [31:0] npc;

    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("inst_pc", inst_pc, m_q[0]);
      chk("inst_data", inst_data, mem_word(m_q[0]));
    end
    chk("misaligned", {31'd0, fetch_misaligned}, {31'd0, m_mis});
    if (inst_valid && irdy) n_deq_obs++;

    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_req_ready  = mrdy;
    inst_ready     = irdy;
    rsp            = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    mem_rsp_valid  = rsp;
    mem_rsp_data   = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;

    exp_rv = (stale_cnt() == 0) && !m_halt && !rv && ((m_q.size() + mem_q.size()) < DEPTH);
    chk("req_valid", {31'd0, mem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("req_addr", mem_req_addr, m_fetch);
    if (mem_req_valid && mrdy) n_hs_obs++;

    req_hs = exp_rv && mrdy;
    deq    = (m_q.size() != 0) && irdy;
    if (deq) void'(m_q.pop_front());
    if (rsp) begin
      e = mem_q.pop_front();
      if (!rv && !m_halt && (e.ep == m_ep)) begin
        m_q.push_back(m_rsp);
        m_rsp = m_rsp + 32'd4;
      end
    end
    if (req_hs) begin
      mem_q.push_back('{addr: m_fetch, due: cyc + lat, ep: m_ep});
      m_fetch = m_fetch + 32'd4;
    end
    if (rv) begin
      m_q.delete();
      m_ep++;
      npc = rpc;
`ifdef IFQ_ALIGN_CHECK_EN
      m_halt = (rpc[1:0] != 2'b00);
      m_mis  = m_halt;
`else
      npc[1:0] = 2'b00;
`endif
      m_fetch = npc;
      m_rsp   = npc;
    end

    @(posedge clk2);
    cyc++;
    @(negedge clk2);
  endtask

  initial begin
    logic [31:0] rpc;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_ep     = 0;
    lat      = 1;
    #2;
    @(negedge clk2);
    do_reset(2);

    // Stalled decode: exactly DEPTH requests, then fetch stops.
    n_hs_obs = 0;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("credit_cap", n_hs_obs, DEPTH);

    // Release decode and stream; fetch resumes at 0x10, then one instruction per cycle.
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
    n_deq_obs = 0;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("throughput", n_deq_obs, 8);

    // Redirect with several requests outstanding at a longer latency.
    lat = 3;
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect in a cycle that carries a response.
    lat = 1;
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Address wrap across the top of memory.
    step(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Misaligned redirect then aligned recovery.
    lat = 2;
    step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      lat = int'($urandom_range(4, 1));
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(15) == 0, rpc, $urandom_range(3) != 0, $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
